// File: rtl/video_fetch.sv
// Raster timing generator and screen-word fetcher for the video shifter.
// Each 16-clock slot with display enabled fetches one RAM word and strobes it.
module video_fetch #(
    parameter int H_TOTAL    = 512,
    parameter int H_SYNC_LEN = 40,
    parameter int H_DE_START = 56,
    parameter int H_DE_LEN   = 320,
    parameter int V_TOTAL    = 313,
    parameter int V_SYNC_LEN = 3,
    parameter int V_DE_START = 63,
    parameter int V_DE_LEN   = 200,
    parameter int ADDR_W     = 21
) (
    input  logic              CLOCK_32,
    input  logic              reset,
    input  logic [ADDR_W-1:0] vbase,
    input  logic              underrun_clr,
    output logic              ram_req,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic              ram_ack,
    input  logic [15:0]       ram_data,
    output logic              de,
    output logic              load,
    output logic [15:0]       data,
    output logic              hsync,
    output logic              vsync,
    output logic              underrun
);

    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC_LEN);
    localparam logic [HW-1:0] H_DE_BEG   = HW'(H_DE_START);
    localparam logic [HW-1:0] H_DE_END   = HW'(H_DE_START + H_DE_LEN);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC_LEN);
    localparam logic [VW-1:0] V_DE_BEG   = VW'(V_DE_START);
    localparam logic [VW-1:0] V_DE_END   = VW'(V_DE_START + V_DE_LEN);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_STROBE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              de_q, de_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              underrun_q, underrun_d;
    logic [3:0]        slot_q, slot_d;
    logic              frame_wrap;
    logic              fetch_ok, fetch_miss;

    // Syncs and de are registered from the next counter values so they move
    // on the same edge as the counters.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        phase_d    = phase_q + 2'd1;
        h_d        = h_q;
        v_d        = v_q;
        frame_wrap = 1'b0;
        if (phase_q == 2'd3) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d        = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_d = v_q + VW'(1);
                end
            end else begin
                h_d = h_q + HW'(1);
            end
        end
        hsync_d = !(h_d < H_SYNC_END);
        vsync_d = !(v_d < V_SYNC_END);
        de_d    = (h_d >= H_DE_BEG) && (h_d < H_DE_END) &&
                  (v_d >= V_DE_BEG) && (v_d < V_DE_END);
        slot_q  = {h_q[1:0], phase_q};
        slot_d  = {h_d[1:0], phase_d};
    end

    always_ff @(posedge CLOCK_32 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks, so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // A missed deadline at s=7 and an ack at s=7 both land directly in STROBE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (slot_d == 4'd0 && de_d) state_d = S_REQ;
            S_REQ:    if (ram_ack || slot_q == 4'd7)
                          state_d = (slot_d == 4'd8) ? S_STROBE : S_HOLD;
            S_HOLD:   if (slot_d == 4'd8) state_d = S_STROBE;
            S_STROBE: if (slot_d == 4'd12) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ram_req = 1'b0;
        load    = 1'b1;
        case (state_q)
            S_REQ:    ram_req = 1'b1;
            S_STROBE: load    = 1'b0;
            default:  ;
        endcase
    end

    always_comb begin
        fetch_ok   = (state_q == S_REQ) && ram_ack;
        fetch_miss = (state_q == S_REQ) && !ram_ack && (slot_q == 4'd7);
        data_d     = data_q;
        addr_d     = addr_q;
        if (fetch_ok)   data_d = ram_data;
        if (fetch_miss) data_d = '0;
        if (fetch_ok || fetch_miss) addr_d = addr_q + ADDR_W'(1);
        if (frame_wrap) addr_d = vbase;
        // A fresh miss outranks a simultaneous clear.
        underrun_d = fetch_miss | (underrun_q & ~underrun_clr);
    end

    always_ff @(posedge CLOCK_32 or posedge reset) begin
        if (reset) begin
            phase_q    <= '0;
            h_q        <= '0;
            v_q        <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            de_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            h_q        <= h_d;
            v_q        <= v_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            de_q       <= de_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            underrun_q <= underrun_d;
        end
    end

    assign ram_addr = addr_q;
    assign de       = de_q;
    assign data     = data_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign underrun = underrun_q;

endmodule
